// File: rtl/sample_packer.sv
// sample_packer
// Packs SAMPLE_WIDTH-bit samples (ADC input or an internal test counter) into
// WORD_WIDTH-bit words, either one sample per word or as a dense LSB-first bit
// stream. Words leave through a 2-entry valid/ready queue. A flush word is
// emitted at end of capture when packed bits remain. Dropped words raise a
// sticky overflow flag that is cleared at the next capture start.
module sample_packer #(
    parameter int SAMPLE_WIDTH = 10,
    parameter int WORD_WIDTH   = 16
) (
    input  logic                    clock,
    input  logic                    nReset,
    input  logic                    collectData,
    input  logic [1:0]              mode,
    input  logic [SAMPLE_WIDTH-1:0] sampleIn,
    output logic [WORD_WIDTH-1:0]   dataOut,
    output logic                    dataValid,
    input  logic                    dataReady,
    output logic                    bufferOverflow,
    output logic                    busy
);

    // Accumulator holds at most WORD_WIDTH-1 leftover bits plus one new sample.
    localparam int ACC_W = WORD_WIDTH + SAMPLE_WIDTH - 1;
    // One extra bit so the OR-in of a sample never loses its top bit.
    localparam int SUM_W = WORD_WIDTH + SAMPLE_WIDTH;
    // Bit counter must represent values up to WORD_WIDTH+SAMPLE_WIDTH-1.
    localparam int BC_W  = $clog2(SUM_W + 1);

    // Capture control state
    logic                    collect_prev_reg;
    logic [1:0]              mode_reg;
    logic [SAMPLE_WIDTH-1:0] cnt_reg,     cnt_next;

    // Packing state
    logic [ACC_W-1:0]        acc_reg,     acc_next;
    logic [BC_W-1:0]         bit_cnt_reg, bit_cnt_next;

    // Output queue state: entry 0 is the head and drives dataOut directly
    logic [WORD_WIDTH-1:0]   q0_reg,      q0_next;
    logic [WORD_WIDTH-1:0]   q1_reg,      q1_next;
    logic [1:0]              q_count_reg, q_count_next;
    logic                    ovf_reg,     ovf_next;

    // Per-edge decode
    logic                    start;
    logic [1:0]              mode_eff;
    logic [SAMPLE_WIDTH-1:0] cnt_eff;
    logic [SAMPLE_WIDTH-1:0] sample;
    logic [ACC_W-1:0]        acc_base;
    logic [BC_W-1:0]         bc_base;
    logic [SUM_W-1:0]        acc_or;
    logic [BC_W-1:0]         bc_sum;
    logic                    produce;
    logic [WORD_WIDTH-1:0]   word;
    logic                    pop;
    logic                    drop;

    assign dataOut        = q0_reg;
    assign dataValid      = (q_count_reg != 2'd0);
    assign bufferOverflow = ovf_reg;
    // collect_prev_reg also covers a pending flush: the flush word is pushed
    // on the same edge that clears it, so busy never dips in between.
    assign busy           = collect_prev_reg | dataValid;

    // Capture start uses the live mode and a fresh counter/accumulator on the
    // very edge that consumes the first sample.
    always_comb begin
        start    = collectData && !collect_prev_reg;
        mode_eff = start ? mode : mode_reg;
        cnt_eff  = start ? '0 : cnt_reg;
        sample   = mode_eff[1] ? cnt_eff : sampleIn;
        acc_base = start ? '0 : acc_reg;
        bc_base  = start ? '0 : bit_cnt_reg;
        acc_or   = {1'b0, acc_base} | (SUM_W'(sample) << bc_base);
        bc_sum   = bc_base + BC_W'(SAMPLE_WIDTH);
    end

    // Sample consumption, packing and end-of-capture flush; yields at most one word
    always_comb begin
        produce      = 1'b0;
        word         = '0;
        acc_next     = acc_reg;
        bit_cnt_next = bit_cnt_reg;
        cnt_next     = cnt_reg;
        if (collectData) begin
            cnt_next = mode_eff[1] ? (cnt_eff + SAMPLE_WIDTH'(1)) : cnt_eff;
            if (mode_eff[0]) begin
                if (bc_sum >= BC_W'(WORD_WIDTH)) begin
                    produce      = 1'b1;
                    word         = acc_or[WORD_WIDTH-1:0];
                    acc_next     = ACC_W'(acc_or >> WORD_WIDTH);
                    bit_cnt_next = bc_sum - BC_W'(WORD_WIDTH);
                end else begin
                    acc_next     = ACC_W'(acc_or);
                    bit_cnt_next = bc_sum;
                end
            end else begin
                produce      = 1'b1;
                word         = WORD_WIDTH'(sample);
                acc_next     = '0;
                bit_cnt_next = '0;
            end
        end else if (collect_prev_reg) begin
            // First idle edge after a capture: emit any partial packed word.
            if (mode_reg[0] && (bit_cnt_reg != '0)) begin
                produce = 1'b1;
                word    = acc_reg[WORD_WIDTH-1:0];
            end
            acc_next     = '0;
            bit_cnt_next = '0;
        end
    end

    // Two-entry queue with simultaneous push/pop and drop-on-full detection
    always_comb begin
        pop          = dataValid && dataReady;
        drop         = 1'b0;
        q0_next      = q0_reg;
        q1_next      = q1_reg;
        q_count_next = q_count_reg;
        case (q_count_reg)
            2'd0: begin
                if (produce) begin
                    q0_next      = word;
                    q_count_next = 2'd1;
                end
            end
            2'd1: begin
                if (pop && produce) begin
                    q0_next = word;
                end else if (pop) begin
                    q_count_next = 2'd0;
                end else if (produce) begin
                    q1_next      = word;
                    q_count_next = 2'd2;
                end
            end
            default: begin
                if (pop && produce) begin
                    q0_next = q1_reg;
                    q1_next = word;
                end else if (pop) begin
                    q0_next      = q1_reg;
                    q_count_next = 2'd1;
                end else if (produce) begin
                    drop = 1'b1;
                end
            end
        endcase
        ovf_next = ovf_reg;
        if (start) begin
            ovf_next = 1'b0;
        end
        if (drop) begin
            ovf_next = 1'b1;
        end
    end

    // Capture control registers; mode is only sampled at capture start
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            collect_prev_reg <= 1'b0;
            mode_reg         <= '0;
            cnt_reg          <= '0;
        end else begin
            collect_prev_reg <= collectData;
            cnt_reg          <= cnt_next;
            if (start) begin
                mode_reg <= mode;
            end
        end
    end

    // Packing registers
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            acc_reg     <= '0;
            bit_cnt_reg <= '0;
        end else begin
            acc_reg     <= acc_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Queue and overflow registers
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            q0_reg      <= '0;
            q1_reg      <= '0;
            q_count_reg <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            q0_reg      <= q0_next;
            q1_reg      <= q1_next;
            q_count_reg <= q_count_next;
            ovf_reg     <= ovf_next;
        end
    end

endmodule

// File: doc/sample_packer.md
# sample_packer

Parametrised sample-to-word packer sitting in the ADC clock domain between the data generator and the FIFO buffer. Accepts one SAMPLE_WIDTH-bit sample per clock while collection is enabled, selects ADC or an internal test counter, and emits WORD_WIDTH-bit words either one-sample-per-word or densely bit-packed. Output is a valid/ready stream through a 2-entry queue, with end-of-capture flush and sticky overflow reporting.

## Interface
- SAMPLE_WIDTH, 10, bits per sample; legal range 1..WORD_WIDTH
- WORD_WIDTH, 16, bits per output word
- clock  in  1  sample clock (ADC clock); all logic on rising edge
- nReset  in  1  asynchronous, active-low reset
- collectData  in  1  1 = consume sampleIn every clock
- mode  in  2  bit0: 1 = packed, 0 = unpacked; bit1: 1 = test counter, 0 = sampleIn
- sampleIn  in  SAMPLE_WIDTH  ADC sample
- dataOut  out  WORD_WIDTH  head-of-queue word
- dataValid  out  1  queue non-empty
- dataReady  in  1  downstream accepts the head word at this edge
- bufferOverflow  out  1  sticky: a produced word was dropped
- busy  out  1  collecting, flush pending, or queue non-empty

## Operation
- Reset: dataOut=0, dataValid=0, bufferOverflow=0, busy=0; queue empty, accumulator=0, bitCount=0, test counter=0.
- Capture start: at the edge where collectData is 1 after being 0, mode is latched into modeReg and test counter is reset to 0; bufferOverflow cleared. mode changes while collecting are ignored.
- Every edge with collectData=1 consumes one sample: sampleIn, or test counter value (counter then increments, wraps 2^SAMPLE_WIDTH-1 -> 0). No back-pressure on input.
- Unpacked: word = sample zero-extended to WORD_WIDTH, one word per sample.
- Packed: LSB-first bit stream. acc |= sample << bitCount; bitCount += SAMPLE_WIDTH; if bitCount >= WORD_WIDTH: produce acc[WORD_WIDTH-1:0], acc >>= WORD_WIDTH, bitCount -= WORD_WIDTH. Accumulator width WORD_WIDTH+SAMPLE_WIDTH-1. Defaults: 8 samples -> 5 words, bitCount returns to 0.
- Flush: at the first edge with collectData=0 after capture, if packed and bitCount>0, produce acc[WORD_WIDTH-1:0] (upper bits zero) and clear acc/bitCount. Unpacked: no flush word.
- Queue: 2 entries, FIFO order. At most one word produced per edge.
- Push and pop on same edge: both occur; no overflow even when full.
- Produced word with queue full and no pop: word dropped, bufferOverflow set, held until next capture start or reset.
- Reset mid-capture: all state cleared immediately, partial word discarded, no flush.

## Timing
- Word produced at edge N is on dataOut with dataValid=1 from just after edge N (latency 1 cycle from sample to output).
- Pop at edge where dataValid && dataReady; next entry (if any) presented after that edge.
- dataOut stable while dataValid=1 and dataReady=0.
- dataOut when dataValid=0: holds last value (don't care for checkers).
- Flush word appears one edge after the edge where collectData is first seen low.
- busy falls after the edge that pops the last word with no flush pending.
- Throughput: unpacked 1 word/clock; packed SAMPLE_WIDTH/WORD_WIDTH words/clock on average.

## Test plan
- Unpacked test mode (mode=2), dataReady=1, 1030 samples -> words 0x0000..0x03FF then 0x0000..0x0005; no overflow.
- Packed test mode (mode=3), dataReady=1, 8 samples -> words 0x0400, 0xC020, 0x0400, 0x6014, 0x01C0; bitCount 0 afterwards, no flush word.
- Packed flush: mode=3, 3 samples then collectData=0 -> 0x0400, then flush word 0x0020 one edge after collectData low.
- Overflow: mode=2, dataReady=0, 3 samples -> bufferOverflow=1 after third edge; raise dataReady -> 0x0000, 0x0001 only; next capture start clears bufferOverflow.
- Full queue with simultaneous pop: mode=2, queue full, dataReady=1 during continuous capture -> no drop, contiguous counter sequence.
- Reset mid-capture: assert nReset=0 after 5 packed samples -> all outputs 0 immediately; new capture with mode=0, sampleIn=0x3FF -> 0x03FF.
